// File: rtl/conv4_ctrl.sv
`default_nettype none
// ============================================================================
// conv4_ctrl : two-row pass sequencer for the Conv4_core 3x3 convolution core
// Rev 1.0
// ============================================================================
module conv4_ctrl #(
    parameter int DATA_W   = 8,
    parameter int DIM_W    = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_W-1:0]      cfg_h,
    input  logic [DIM_W-1:0]      cfg_w,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DIM_W-1:0]      fm_row,
    output logic [DIM_W-1:0]      fm_col,
    output logic [1:0]            filt_col,
    output logic                  core_en,
    output logic                  core_clr,
    input  logic [2*DATA_W-1:0]   core_sum1,
    input  logic [2*DATA_W-1:0]   core_sum2,
    input  logic                  core_end,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   out_sum1,
    output logic [2*DATA_W-1:0]   out_sum2,
    output logic                  out_pair,
    output logic [DIM_W-1:0]      out_row,
    output logic [DIM_W-1:0]      out_col
);

    localparam int                WCNT_W      = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WCNT_W-1:0] C_WAIT_LAST = WCNT_W'(WAIT_MAX - 1);
    localparam logic [DIM_W-1:0]  C_MIN_DIM   = DIM_W'(3);
    localparam logic [DIM_W:0]    C_ONE_X     = 1;
    localparam logic [DIM_W:0]    C_TWO_X     = 2;
    localparam logic [1:0]        C_K_LAST    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FEED = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [DIM_W-1:0]     r_h;
    logic [DIM_W-1:0]     r_w;
    logic [DIM_W-1:0]     r_row;
    logic [DIM_W-1:0]     r_col;
    logic [1:0]           r_k;
    logic [WCNT_W-1:0]    r_wait;
    logic                 r_err;
    logic [2*DATA_W-1:0]  r_sum1;
    logic [2*DATA_W-1:0]  r_sum2;
    logic                 r_pair;
    logic [DIM_W-1:0]     r_orow;
    logic [DIM_W-1:0]     r_ocol;

    logic                 w_cfg_bad;
    logic [DIM_W-1:0]     w_h_last;
    logic [DIM_W-1:0]     w_w_last;
    logic                 w_col_wrap;
    logic [DIM_W:0]       w_row_adv;
    logic                 w_row_over;
    logic                 w_pair;
    logic                 w_wait_last;

    // Row arithmetic is one bit wider so row+2 can never wrap past the limit.
    assign w_cfg_bad   = (cfg_h < C_MIN_DIM) || (cfg_w < C_MIN_DIM);
    assign w_h_last    = r_h - C_MIN_DIM;
    assign w_w_last    = r_w - C_MIN_DIM;
    assign w_col_wrap  = (r_col >= w_w_last);
    assign w_row_adv   = {1'b0, r_row} + C_TWO_X;
    assign w_row_over  = (w_row_adv > {1'b0, w_h_last});
    assign w_pair      = (({1'b0, r_row} + C_ONE_X) <= {1'b0, w_h_last});
    assign w_wait_last = (r_wait == C_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        done      = 1'b0;
        core_en   = 1'b0;
        core_clr  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_cfg_bad ? S_DONE : S_FEED;
                end
            end
            S_FEED: begin
                busy     = 1'b1;
                core_en  = 1'b1;
                core_clr = (r_k == 2'd0);
                if (r_k == C_K_LAST) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                busy    = 1'b1;
                core_en = 1'b1;
                if (core_end) begin
                    w_next = S_OUT;
                end else if (w_wait_last) begin
                    w_next = S_DONE;
                end
            end
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = (w_col_wrap && w_row_over) ? S_DONE : S_FEED;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h    <= '0;
            r_w    <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_k    <= '0;
            r_wait <= '0;
            r_err  <= 1'b0;
            r_sum1 <= '0;
            r_sum2 <= '0;
            r_pair <= 1'b0;
            r_orow <= '0;
            r_ocol <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_h   <= cfg_h;
                        r_w   <= cfg_w;
                        r_err <= w_cfg_bad;
                        r_row <= '0;
                        r_col <= '0;
                        r_k   <= '0;
                    end
                end
                S_FEED: begin
                    r_wait <= '0;
                    if (r_k != C_K_LAST) begin
                        r_k <= r_k + 2'd1;
                    end
                end
                S_WAIT: begin
                    if (core_end) begin
                        r_sum1 <= core_sum1;
                        r_sum2 <= core_sum2;
                        r_pair <= w_pair;
                        r_orow <= r_row;
                        r_ocol <= r_col;
                    end else if (w_wait_last) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_k <= '0;
                        if (w_col_wrap) begin
                            r_col <= '0;
                            r_row <= w_row_adv[DIM_W-1:0];
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // k holds at 2 after the feed, so the feed address stays put through WAIT/OUT.
    assign fm_row   = r_row;
    assign fm_col   = r_col + {{(DIM_W-2){1'b0}}, r_k};
    assign filt_col = r_k;
    assign err      = r_err;
    assign out_sum1 = r_sum1;
    assign out_sum2 = r_sum2;
    assign out_pair = r_pair;
    assign out_row  = r_orow;
    assign out_col  = r_ocol;

endmodule
`default_nettype wire

// File: tb/tb_conv4_ctrl.sv
`default_nettype none
// ============================================================================
// tb_conv4_ctrl : scoreboard bench for conv4_ctrl with a behavioural core model
// Rev 1.0
// ============================================================================
module tb_conv4_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cfg_h = 8'd0;
    logic [7:0]  cfg_w = 8'd0;
    logic        busy, done, err;
    logic [7:0]  fm_row, fm_col;
    logic [1:0]  filt_col;
    logic        core_en, core_clr;
    logic [15:0] core_sum1 = 16'd0;
    logic [15:0] core_sum2 = 16'd0;
    logic        core_end = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum1, out_sum2;
    logic        out_pair;
    logic [7:0]  out_row, out_col;

    conv4_ctrl #(.DATA_W(8), .DIM_W(8), .WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_h(cfg_h), .cfg_w(cfg_w),
        .busy(busy), .done(done), .err(err),
        .fm_row(fm_row), .fm_col(fm_col), .filt_col(filt_col),
        .core_en(core_en), .core_clr(core_clr),
        .core_sum1(core_sum1), .core_sum2(core_sum2), .core_end(core_end),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum1(out_sum1), .out_sum2(out_sum2), .out_pair(out_pair),
        .out_row(out_row), .out_col(out_col)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] s1;
        logic [15:0] s2;
        logic        pair;
        logic [7:0]  row;
        logic [7:0]  col;
    } res_t;

    typedef struct packed {
        logic [7:0] col;
        logic [1:0] filt;
    } feed_t;

    res_t  exp_q[$];
    res_t  obs_q[$];
    feed_t feed_q[$];
    res_t  mon_r;

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int valid_seen = 0;
    int fcnt = 99;
    int end_delay = 0;
    bit never_end = 1'b0;
    logic [7:0] row0 = 8'd0;
    logic [7:0] col0 = 8'd0;

    function automatic logic [15:0] f1(input logic [7:0] r, input logic [7:0] c);
        return {r, c} ^ 16'h5A00;
    endfunction

    function automatic logic [15:0] f2(input logic [7:0] r, input logic [7:0] c);
        return {c, r} ^ 16'h00A5;
    endfunction

    // Core model: sums depend on the window origin it was actually fed.
    always @(negedge clk) begin
        core_end = 1'b0;
        if (core_clr) begin
            fcnt = 0;
            row0 = fm_row;
            col0 = fm_col;
        end else if (core_en) begin
            fcnt++;
        end
        if (core_en && fcnt < 3) feed_q.push_back({fm_col, filt_col});
        if (core_en && !never_end && fcnt == 3 + end_delay) begin
            core_end  = 1'b1;
            core_sum1 = f1(row0, col0);
            core_sum2 = f2(row0, col0);
        end
        if (done) done_cnt++;
        if (out_valid) valid_seen++;
        if (out_valid && out_ready) begin
            mon_r.s1   = out_sum1;
            mon_r.s2   = out_sum2;
            mon_r.pair = out_pair;
            mon_r.row  = out_row;
            mon_r.col  = out_col;
            obs_q.push_back(mon_r);
        end
    end

    task automatic do_start(input int h, input int w);
        res_t e;
        exp_q.delete();
        obs_q.delete();
        feed_q.delete();
        done_cnt   = 0;
        valid_seen = 0;
        if (h >= 3 && w >= 3) begin
            for (int r = 0; r <= h - 3; r += 2) begin
                for (int c = 0; c <= w - 3; c++) begin
                    e.row  = 8'(r);
                    e.col  = 8'(c);
                    e.pair = (r + 1 <= h - 3);
                    e.s1   = f1(8'(r), 8'(c));
                    e.s2   = f2(8'(r), 8'(c));
                    exp_q.push_back(e);
                end
            end
        end
        @(posedge clk); #2;
        cfg_h = 8'(h);
        cfg_w = 8'(w);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int busy_cycles,
                             output bit timed_out, output logic busy_at_done);
        busy_cycles  = 0;
        timed_out    = 1'b1;
        busy_at_done = 1'bx;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                timed_out    = 1'b0;
                busy_at_done = busy;
                break;
            end
            if (busy) busy_cycles++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, err, core_en, core_clr, out_valid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, err, core_en, core_clr, out_valid});
        end
        n_cmp++;
        if ({fm_row, fm_col, filt_col} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h expected 0", {fm_row, fm_col, filt_col});
        end
        n_cmp++;
        if ({out_sum1, out_sum2, out_pair, out_row, out_col} !== 49'd0) begin
            n_fail++;
            $display("FAIL reset_out: got %h expected 0", {out_sum1, out_sum2, out_pair, out_row, out_col});
        end
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic test_basic_4x4();
        int bc; bit to; logic bd; res_t o, e; feed_t f;
        out_ready = 1'b1;
        do_start(4, 4);
        wait_done(100, bc, to, bd);
        n_cmp++;
        if (to || done_cnt != 1) begin
            n_fail++;
            $display("FAIL basic_done: timeout=%0d pulses=%0d expected 0/1", to, done_cnt);
        end
        n_cmp++;
        if (err !== 1'b0 || bc != 10) begin
            n_fail++;
            $display("FAIL basic_err_busy: err=%b busy_cycles=%0d expected 0/10", err, bc);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o.s1 !== e.s1 || o.s2 !== e.s2 || o.pair !== e.pair || o.row !== e.row || o.col !== e.col) begin
                n_fail++;
                $display("FAIL basic_result: got %h expected %h", o, e);
            end
        end
        n_cmp++;
        if (feed_q.size() != 6) begin
            n_fail++;
            $display("FAIL basic_feed_len: got %0d expected 6", feed_q.size());
        end
        for (int i = 0; i < 6 && feed_q.size() > 0; i++) begin
            f = feed_q.pop_front();
            n_cmp++;
            if (f.col !== 8'(i / 3 + i % 3) || f.filt !== 2'(i % 3)) begin
                n_fail++;
                $display("FAIL basic_feed[%0d]: got col=%0d filt=%0d expected col=%0d filt=%0d",
                         i, f.col, f.filt, i / 3 + i % 3, i % 3);
            end
        end
    endtask

    task automatic test_odd_5x3();
        int bc; bit to; logic bd; res_t o, e;
        do_start(5, 3);
        wait_done(100, bc, to, bd);
        n_cmp++;
        if (to || done_cnt != 1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_done: timeout=%0d pulses=%0d err=%b expected 0/1/0", to, done_cnt, err);
        end
        n_cmp++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            n_fail++;
            $display("FAIL odd_count: got %0d expected 2", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o.s1 !== e.s1 || o.pair !== e.pair || o.row !== e.row || o.col !== e.col ||
                (e.pair && o.s2 !== e.s2)) begin
                n_fail++;
                $display("FAIL odd_result: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_backpressure();
        int bc; bit to; logic bd; res_t o, e; bit seen;
        logic [48:0] snap;
        out_ready = 1'b0;
        do_start(4, 4);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL bp_valid: got no out_valid expected 1 within 30 cycles");
        end
        snap = {out_sum1, out_sum2, out_pair, out_row, out_col};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_sum1, out_sum2, out_pair, out_row, out_col} !== snap || out_valid !== 1'b1 ||
                core_en !== 1'b0 || core_clr !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got out=%h v=%b en=%b clr=%b expected out=%h v=1 en=0 clr=0",
                         i, {out_sum1, out_sum2, out_pair, out_row, out_col}, out_valid, core_en, core_clr, snap);
            end
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (core_clr !== 1'b1 || core_en !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_restart: got clr=%b en=%b v=%b expected 1/1/0", core_clr, core_en, out_valid);
        end
        wait_done(100, bc, to, bd);
        n_cmp++;
        if (to || done_cnt != 1 || obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL bp_done: timeout=%0d pulses=%0d results=%0d expected 0/1/2", to, done_cnt, obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL bp_result: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_bad_cfg();
        int bc; bit to; logic bd;
        do_start(2, 6);
        wait_done(5, bc, to, bd);
        n_cmp++;
        if (to || bc != 0 || bd !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_done: timeout=%0d busy_cycles=%0d busy=%b expected 0/0/0", to, bc, bd);
        end
        n_cmp++;
        if (err !== 1'b1 || valid_seen != 0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL bad_err: err=%b valid_cycles=%0d pulses=%0d expected 1/0/1", err, valid_seen, done_cnt);
        end
    endtask

    task automatic test_timeout();
        int bc; bit to; logic bd;
        never_end = 1'b1;
        do_start(4, 4);
        wait_done(80, bc, to, bd);
        never_end = 1'b0;
        n_cmp++;
        if (to || done_cnt != 1 || bd !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_done: timeout=%0d pulses=%0d busy=%b expected 0/1/0", to, done_cnt, bd);
        end
        n_cmp++;
        if (bc != 18 || err !== 1'b1 || valid_seen != 0) begin
            n_fail++;
            $display("FAIL tmo_len: busy_cycles=%0d err=%b valid_cycles=%0d expected 18/1/0", bc, err, valid_seen);
        end
    endtask

    task automatic test_reset_mid();
        int bc; bit to; logic bd; res_t o, e;
        end_delay = 6;
        do_start(4, 4);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || core_en !== 1'b1 || core_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait: got busy=%b en=%b clr=%b expected 1/1/0", busy, core_en, core_clr);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, err, core_en, core_clr, out_valid} !== 6'b0 ||
            {fm_row, fm_col, filt_col, out_sum1, out_sum2, out_pair, out_row, out_col} !== 67'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got ctrl=%b data=%h expected all 0",
                     {busy, done, err, core_en, core_clr, out_valid},
                     {fm_row, fm_col, filt_col, out_sum1, out_sum2, out_pair, out_row, out_col});
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (done_cnt != 0 || valid_seen != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_quiet: pulses=%0d valid_cycles=%0d busy=%b expected 0/0/0", done_cnt, valid_seen, busy);
        end
        end_delay = 0;
        do_start(4, 4);
        wait_done(100, bc, to, bd);
        n_cmp++;
        if (to || done_cnt != 1 || obs_q.size() != 2 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rerun: timeout=%0d pulses=%0d results=%0d err=%b expected 0/1/2/0",
                     to, done_cnt, obs_q.size(), err);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mid_result: got %h expected %h", o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_4x4();
        test_odd_5x3();
        test_backpressure();
        test_bad_cfg();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run expected finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
